// File: rtl/arb_pkg.sv
// Shared types and the round-robin search used by the 16-way arbiter.
package arb_pkg;
  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // First set request at or after start, wrapping from 15 back to 0.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [ID_W-1:0]  start);
    pick_t           res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + ID_W'(i);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/decoder_4to16.sv
// 4-to-16 one-hot decoder; {w,x,y,z} is the select with w as MSB.
module decoder_4to16 (
  input  logic w,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic d8,
  output logic d9,
  output logic d10,
  output logic d11,
  output logic d12,
  output logic d13,
  output logic d14,
  output logic d15
);
  logic [3:0]  w_sel;
  logic [15:0] w_d;

  assign w_sel = {w, x, y, z};
  assign w_d   = 16'b1 << w_sel;

  assign d0  = w_d[0];
  assign d1  = w_d[1];
  assign d2  = w_d[2];
  assign d3  = w_d[3];
  assign d4  = w_d[4];
  assign d5  = w_d[5];
  assign d6  = w_d[6];
  assign d7  = w_d[7];
  assign d8  = w_d[8];
  assign d9  = w_d[9];
  assign d10 = w_d[10];
  assign d11 = w_d[11];
  assign d12 = w_d[12];
  assign d13 = w_d[13];
  assign d14 = w_d[14];
  assign d15 = w_d[15];
endmodule

// File: rtl/arb_rr16_ctrl.sv
// Round-robin arbiter for 16 clients with hold-until-release and an optional
// fairness timeout; the grant vector is a gated decode of the registered owner.
//
// state | meaning
// IDLE  | no owner, gnt all zeros
// GRANT | r_gnt_id owns the resource
module arb_rr16_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t             r_state,  w_state_nxt;
  logic [ID_W-1:0]    r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0]    r_last,   w_last_nxt;
  logic [HOLD_W-1:0]  r_hold,   w_hold_nxt;

  logic [N_REQ-1:0]   w_others;
  logic [N_REQ-1:0]   w_dec;
  pick_t              w_pick_all;
  pick_t              w_pick_other;
  logic               w_timeout;

  assign w_others     = req & ~(N_REQ'(1) << r_gnt_id);
  assign w_pick_all   = rr_pick(req, r_last + 1'b1);
  assign w_pick_other = rr_pick(w_others, r_last + 1'b1);
  // >= rather than == so a saturated counter still times out once a rival appears.
  assign w_timeout    = (MAX_HOLD != 0) && (r_hold >= HOLD_LAST) && (|w_others);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt_id <= '0;
      r_last   <= ID_W'(N_REQ - 1);
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_last   <= w_last_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_id_nxt = r_gnt_id;
    w_last_nxt   = r_last;
    w_hold_nxt   = r_hold;
    case (r_state)
      IDLE: begin
        if (w_pick_all.found) begin
          w_state_nxt  = GRANT;
          w_gnt_id_nxt = w_pick_all.idx;
          w_last_nxt   = w_pick_all.idx;
          w_hold_nxt   = '0;
        end
      end
      GRANT: begin
        if (!req[r_gnt_id]) begin
          if (w_pick_all.found) begin
            w_gnt_id_nxt = w_pick_all.idx;
            w_last_nxt   = w_pick_all.idx;
            w_hold_nxt   = '0;
          end else begin
            w_state_nxt  = IDLE;
          end
        end else if (w_timeout) begin
          w_gnt_id_nxt = w_pick_other.idx;
          w_last_nxt   = w_pick_other.idx;
          w_hold_nxt   = '0;
        end else if (r_hold != HOLD_SAT) begin
          w_hold_nxt   = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  decoder_4to16 u_dec (
    .w   (r_gnt_id[3]),
    .x   (r_gnt_id[2]),
    .y   (r_gnt_id[1]),
    .z   (r_gnt_id[0]),
    .d0  (w_dec[0]),
    .d1  (w_dec[1]),
    .d2  (w_dec[2]),
    .d3  (w_dec[3]),
    .d4  (w_dec[4]),
    .d5  (w_dec[5]),
    .d6  (w_dec[6]),
    .d7  (w_dec[7]),
    .d8  (w_dec[8]),
    .d9  (w_dec[9]),
    .d10 (w_dec[10]),
    .d11 (w_dec[11]),
    .d12 (w_dec[12]),
    .d13 (w_dec[13]),
    .d14 (w_dec[14]),
    .d15 (w_dec[15])
  );

  assign gnt_valid = (r_state == GRANT);
  assign gnt_id    = r_gnt_id;
  assign gnt       = w_dec & {N_REQ{gnt_valid}};
endmodule

// File: tb/tb_arb_rr16_ctrl.sv
// Bench for arb_rr16_ctrl: directed vector table, corner sequences and random
// traffic, with two instances (MAX_HOLD=4 and MAX_HOLD=0) checked against a model.
module tb_arb_rr16_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt4, gnt0;
  logic [3:0]  id4, id0;
  logic        v4, v0;

  always #5 clk = ~clk;

  arb_rr16_ctrl #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4)
  );
  arb_rr16_ctrl #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: owner index (-1 = idle), last owner, cycles the owner has held so far.
  int m_owner[2];
  int m_last[2];
  int m_held[2];
  int m_max[2] = '{4, 0};

  typedef struct {
    logic [15:0] req;
    logic [15:0] gnt;
    logic        v;
    logic [3:0]  id;
  } vec_t;
  vec_t tbl[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int start);
    for (int i = 0; i < 16; i++) begin
      if (r[(start + i) % 16]) return (start + i) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = 15;
      m_held[k]  = 0;
    end
  endtask

  task automatic model_step(input logic [15:0] r);
    for (int k = 0; k < 2; k++) begin
      int          w;
      logic [15:0] oth;
      if (m_owner[k] < 0) begin
        w = pick(r, m_last[k] + 1);
        if (w >= 0) begin
          m_owner[k] = w; m_last[k] = w; m_held[k] = 1;
        end
      end else begin
        oth = r & ~(16'd1 << m_owner[k]);
        if (!r[m_owner[k]]) begin
          w = pick(r, m_last[k] + 1);
          m_owner[k] = w;
          if (w >= 0) begin
            m_last[k] = w; m_held[k] = 1;
          end
        end else if (m_max[k] != 0 && m_held[k] >= m_max[k] && oth != 16'd0) begin
          w = pick(oth, m_last[k] + 1);
          m_owner[k] = w; m_last[k] = w; m_held[k] = 1;
        end else begin
          m_held[k]++;
        end
      end
    end
  endtask

  task automatic check_models(input logic [15:0] r);
    for (int k = 0; k < 2; k++) begin
      logic [15:0] g;
      logic [3:0]  id;
      logic        v;
      logic [15:0] eg;
      g  = (k == 0) ? gnt4 : gnt0;
      id = (k == 0) ? id4  : id0;
      v  = (k == 0) ? v4   : v0;
      eg = (m_owner[k] >= 0) ? (16'd1 << m_owner[k]) : 16'd0;
      cmp($sformatf("model_gnt[%0d]", k), g, eg);
      cmp($sformatf("model_valid[%0d]", k), v, m_owner[k] >= 0);
      if (m_owner[k] >= 0) cmp($sformatf("model_id[%0d]", k), id, m_owner[k]);
      cmp($sformatf("onehot0[%0d]", k), $onehot0(g), 1);
      if (v) cmp($sformatf("granted_w_req[%0d]", k), r[id], 1);
    end
  endtask

  task automatic step(input logic [15:0] r);
    req = r;
    @(posedge clk);
    #1;
    model_step(r);
    check_models(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cmp("rst_gnt4", gnt4, 0);
    cmp("rst_valid4", v4, 0);
    cmp("rst_id4", id4, 0);
    cmp("rst_gnt0", gnt0, 0);
    cmp("rst_valid0", v0, 0);
  endtask

  task automatic add(input logic [15:0] r, input logic [15:0] g, input logic v, input logic [3:0] id, input int n);
    vec_t e;
    e.req = r; e.gnt = g; e.v = v; e.id = id;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] r;

    rst = 1'b1;
    req = 16'd0;
    model_reset();

    // Directed table against the MAX_HOLD=4 instance.
    add(16'h0001, 16'h0001, 1, 4'd0, 1);
    add(16'h0000, 16'h0000, 0, 4'd0, 1);
    add(16'h0020, 16'h0020, 1, 4'd5, 1);
    add(16'h0000, 16'h0000, 0, 4'd0, 1);
    add(16'h0003, 16'h0001, 1, 4'd0, 4);
    add(16'h0003, 16'h0002, 1, 4'd1, 4);
    add(16'h0003, 16'h0001, 1, 4'd0, 1);
    add(16'h0001, 16'h0001, 1, 4'd0, 6);
    add(16'h0003, 16'h0002, 1, 4'd1, 1);
    add(16'h8001, 16'h8000, 1, 4'd15, 1);
    add(16'h0001, 16'h0001, 1, 4'd0, 1);
    add(16'h0000, 16'h0000, 0, 4'd0, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req);
      cmp($sformatf("tbl_gnt[%0d]", i), gnt4, tbl[i].gnt);
      cmp($sformatf("tbl_valid[%0d]", i), v4, tbl[i].v);
      if (tbl[i].v) cmp($sformatf("tbl_id[%0d]", i), id4, tbl[i].id);
    end

    // Fair rotation: every owner drops its own bit for one cycle on grant.
    do_reset();
    step(16'hFFFF);
    cmp("rot_first4", id4, 0);
    cmp("rot_first0", id0, 0);
    for (int n = 1; n <= 16; n++) begin
      step(16'hFFFF & ~(16'd1 << ((n - 1) % 16)));
      cmp($sformatf("rot_id4[%0d]", n), id4, n % 16);
      cmp($sformatf("rot_id0[%0d]", n), id0, n % 16);
      cmp($sformatf("rot_valid0[%0d]", n), v0, 1);
    end

    // Wrap-around from last=14.
    do_reset();
    step(16'h4000);
    cmp("wrap_14", id4, 14);
    step(16'h8001);
    cmp("wrap_15", id4, 15);
    step(16'h0001);
    cmp("wrap_0", id4, 0);

    // No limit: client 0 keeps the grant under contention.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(16'h0003);
      cmp($sformatf("nolimit_id0[%0d]", i), id0, 0);
    end

    // Asynchronous reset mid-grant, then first grant after release of reset.
    do_reset();
    step(16'h0001);
    #3 rst = 1'b1;
    #1;
    cmp("async_gnt4", gnt4, 0);
    cmp("async_valid4", v4, 0);
    cmp("async_id4", id4, 0);
    cmp("async_gnt0", gnt0, 0);
    cmp("async_valid0", v0, 0);
    req = 16'h0100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(16'h0100);
    cmp("post_rst_gnt4", gnt4, 16'h0100);

    // Random traffic against the model.
    do_reset();
    prev = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: r = 16'd0;
        1: r = 16'd1 << $urandom_range(0, 15);
        2: r = 16'($urandom() & $urandom());
        3: r = prev & ~gnt4;
        default: r = prev;
      endcase
      step(r);
      prev = r;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arb_rr16_ctrl.md
# arb_rr16_ctrl

Round-robin arbiter that shares one 16-way resource among 16 requesters. It also sequences the existing 4-to-16 decoder that produces the one-hot grant vector. Each cycle the arbiter holds a registered 4-bit owner index and a valid flag; the decoder expands that index into `gnt[15:0]`. The block sits between requesting clients and a shared bus or memory port, and supports hold-until-release with an optional fairness timeout.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive grant cycles for one owner while another requester waits. 0 means no limit.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  16  level request per client; bit i belongs to client i.
- `gnt`  out  16  one-hot grant, all zeros when idle.
- `gnt_id`  out  4  index of the current owner; meaningful only when `gnt_valid` is 1.
- `gnt_valid`  out  1  a grant is active.

## Operation
- States: IDLE (no owner) and GRANT (owner = `gnt_id`).
- Round-robin search:
  - starts at `last+1` and wraps 15→0, where `last` is the most recent owner (reset value 15, so index 0 wins first).
  - The first set `req` bit in that order wins.
- IDLE → GRANT when any `req` bit is 1. On the same edge: `gnt_id` = winner, `last` = winner, hold counter = 0.
- GRANT, owner's `req` still 1, and the limit not reached: stay. Hold counter increments and saturates at `MAX_HOLD`.
- GRANT, owner's `req` drops to 0:
  - On the same edge, re-arbitrate among the remaining requests.
  - If any remain, switch directly to the winner with no idle cycle.
  - If none remain, go to IDLE.
- Timeout, when `MAX_HOLD`≠0, the hold counter = `MAX_HOLD`-1, and any other `req` bit is 1:
  - Force a switch to the next round-robin winner, excluding the owner.
  - Hold counter returns to 0.
  - If no other request is pending, the owner keeps the grant and the counter stays saturated.
- `gnt` = decoder(`gnt_id`) ANDed with `gnt_valid`. It is always one-hot or zero, never multi-hot.
- Requests are sampled, not latched. A pulse that is never granted is lost, and clients hold `req` until granted.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, state IDLE, `last`=15, hold counter=0.
- Reset asserted mid-grant clears all outputs immediately (asynchronous). The first grant comes on the first rising edge after `rst` deasserts with `req` non-zero.
- Latency from `req` rising to grant: 1 cycle. `req` is sampled at edge N and `gnt` is valid after edge N.
- Handover latency: 1 cycle. The owner drops `req` before edge N, and the next owner's `gnt` is valid after edge N.
- An owner granted at edge N can hold the grant for at most `MAX_HOLD` cycles under contention. The switch happens at edge N+`MAX_HOLD`.
- Simultaneous owner release and timeout: treated as a release. The result is the same winner.
- All outputs are registered or pure decode of registers; there is no combinational path from `req` to `gnt`.

## Structure
- Package `arb_pkg`:
  - `N_REQ`=16 and `ID_W`=4
  - state enum {IDLE, GRANT}
  - function `rr_pick(req, start)` returning a winner index and a found flag.
- One sub-module: the existing `decoder_4to16`, instantiated with `gnt_id[3:0]` on w,x,y,z (MSB on w). Its d0..d15 outputs are gated by `gnt_valid` to form `gnt`.
- The hold counter width is large enough to represent `MAX_HOLD`.

## Test plan
- Reset then single request: `req`=0x0001 → after 1 edge `gnt`=0x0001, `gnt_id`=0, `gnt_valid`=1. Assert `rst` mid-grant → all outputs 0 immediately.
- Fair rotation: `req`=0xFFFF held, `MAX_HOLD`=0, each owner drops its own bit for one cycle on grant → owners are 0,1,2,…,15,0 in order, with no gaps.
- Wrap-around: `last`=14, `req`=0x8001 → grant goes to 15. After 15 releases, grant goes to 0.
- Timeout: `MAX_HOLD`=4, `req`=0x0003 held → client 0 holds for 4 cycles, then client 1 holds for 4, alternating. With `req`=0x0001 only, client 0 holds indefinitely.
- Release to idle: sole owner 5 drops `req` → next edge `gnt`=0, `gnt_valid`=0. A new request `req`=0x0020 is then granted after 1 edge.
- Invariant checks every cycle:
  - `gnt` is $onehot0.
  - `gnt` equals decoder(`gnt_id`) when `gnt_valid`=1.
  - `gnt` is never granted to a client whose `req` was 0 at the sampling edge.
